// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with private HI/LO registers.
// MULT/MULTU use radix-2 shift-add and DIV/DIVU use restoring division, one bit per cycle.
// Signed operations run on magnitudes, and the sign is corrected in FIX.
// Optional build macro MULDIV_EARLY_TERM_EN: a multiply leaves RUN as soon as
// the remaining multiplier bits are all zero. Results are the same either way.
//
// state  | meaning
// S_IDLE | waiting for start; MTHI/MTLO writes accepted
// S_RUN  | one multiply/divide iteration per cycle
// S_FIX  | sign correction, HI/LO write, o_done pulse
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_opA,
    input  logic [WIDTH-1:0] i_opB,
    input  logic             i_wr_hi,
    input  logic             i_wr_lo,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_dbz,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // r_acc holds the product (multiply) or {remainder, quotient} (divide).
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_x;        // shifted multiplicand
    logic [WIDTH-1:0]   r_y;        // multiplier (shifts right) or divisor (static)
    logic [CW-1:0]      r_cnt;      // iterations left, including the current one
    logic               r_is_div;
    logic               r_neg_res;  // negate product / quotient in FIX
    logic               r_neg_rem;  // negate remainder in FIX
    logic               r_done;
    logic               r_dbz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept;
    logic               w_signed;
    logic               w_is_div;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_dbz_start;

    logic [2*WIDTH-1:0] w_mul_sum;
    logic [WIDTH-1:0]   w_y_shr;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ok;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;
    logic               w_last;

    logic [2*WIDTH-1:0] w_prod_neg;
    logic [WIDTH-1:0]   w_acc_hi;
    logic [WIDTH-1:0]   w_acc_lo;
    logic [WIDTH-1:0]   w_hi_fix;
    logic [WIDTH-1:0]   w_lo_fix;

    // Operand decode at start: the op is signed when i_op[0]=0, and a divide when i_op[1]=1.
    assign w_accept    = i_start && (r_state == S_IDLE);
    assign w_signed    = ~i_op[0];
    assign w_is_div    = i_op[1];
    assign w_a_neg     = w_signed & i_opA[WIDTH-1];
    assign w_b_neg     = w_signed & i_opB[WIDTH-1];
    assign w_a_mag     = w_a_neg ? -i_opA : i_opA;
    assign w_b_mag     = w_b_neg ? -i_opB : i_opB;
    assign w_dbz_start = w_is_div && (i_opB == '0);

    // Shift-add step.
    assign w_mul_sum = r_acc + r_x;
    assign w_y_shr   = r_y >> 1;

    // Restoring divide step. The top bit of the difference is set only when the trial subtraction underflowed.
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_y};
    assign w_div_ok    = ~w_div_diff[WIDTH];
    assign w_rem_nxt   = w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
    assign w_quo_nxt   = {r_acc[WIDTH-2:0], w_div_ok};

`ifdef MULDIV_EARLY_TERM_EN
    assign w_last = (r_cnt == CW'(1)) || (!r_is_div && (w_y_shr == '0));
`else
    assign w_last = (r_cnt == CW'(1));
`endif

    // Sign correction. A divide-by-zero result is stored raw with both negate flags clear, so it passes through unchanged.
    assign w_prod_neg = -r_acc;
    assign w_acc_hi   = r_acc[2*WIDTH-1:WIDTH];
    assign w_acc_lo   = r_acc[WIDTH-1:0];
    assign w_hi_fix   = r_is_div ? (r_neg_rem ? -w_acc_hi : w_acc_hi)
                                 : (r_neg_res ? w_prod_neg[2*WIDTH-1:WIDTH] : w_acc_hi);
    assign w_lo_fix   = r_is_div ? (r_neg_res ? -w_acc_lo : w_acc_lo)
                                 : (r_neg_res ? w_prod_neg[WIDTH-1:0] : w_acc_lo);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. A divide-by-zero goes straight to FIX.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_dbz_start ? S_FIX : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, result write and MTHI/MTLO.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc     <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_wr_hi) begin
                        r_hi <= i_wdata;
                    end
                    if (i_wr_lo) begin
                        r_lo <= i_wdata;
                    end
                    if (w_accept) begin
                        r_is_div <= w_is_div;
                        r_cnt    <= CW'(WIDTH);
                        r_dbz    <= w_dbz_start;
                        if (w_dbz_start) begin
                            r_acc     <= {i_opA, {WIDTH{1'b1}}};
                            r_x       <= '0;
                            r_y       <= '0;
                            r_neg_res <= 1'b0;
                            r_neg_rem <= 1'b0;
                        end else if (w_is_div) begin
                            r_acc     <= {{WIDTH{1'b0}}, w_a_mag};
                            r_x       <= '0;
                            r_y       <= w_b_mag;
                            r_neg_res <= w_a_neg ^ w_b_neg;
                            r_neg_rem <= w_a_neg;
                        end else begin
                            r_acc     <= '0;
                            r_x       <= {{WIDTH{1'b0}}, w_a_mag};
                            r_y       <= w_b_mag;
                            r_neg_res <= w_a_neg ^ w_b_neg;
                            r_neg_rem <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_is_div) begin
                        r_acc <= {w_rem_nxt, w_quo_nxt};
                    end else begin
                        if (r_y[0]) begin
                            r_acc <= w_mul_sum;
                        end
                        r_x <= r_x << 1;
                        r_y <= w_y_shr;
                    end
                end
                S_FIX: begin
                    r_hi   <= w_hi_fix;
                    r_lo   <= w_lo_fix;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_busy = (r_state != S_IDLE);
    assign o_done = r_done;
    assign o_dbz  = r_dbz;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed cases plus random operations checked against an arithmetic reference model.
module tb_muldiv_unit;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [1:0]  i_op = 2'd0;
    logic [31:0] i_opA = '0;
    logic [31:0] i_opB = '0;
    logic        i_wr_hi = 1'b0;
    logic        i_wr_lo = 1'b0;
    logic [31:0] i_wdata = '0;
    logic        o_busy, o_done, o_dbz;
    logic [31:0] o_hi, o_lo;

    int n_assert = 0;
    int n_fail   = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_op(i_op),
        .i_opA(i_opA), .i_opB(i_opB), .i_wr_hi(i_wr_hi), .i_wr_lo(i_wr_lo),
        .i_wdata(i_wdata), .o_busy(o_busy), .o_done(o_done), .o_dbz(o_dbz),
        .o_hi(o_hi), .o_lo(o_lo)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Reference model: plain wide arithmetic plus the latency rule.
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo,
                         output logic dbz, output int lat);
        longint sa, sb, q, r;
        logic [63:0] p, qv, rv;
        logic [31:0] mag;
        int h;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        dbz = 1'b0;
        lat = 33;
        if (op[1] && b == 32'd0) begin
            hi  = a;
            lo  = 32'hFFFF_FFFF;
            dbz = 1'b1;
            lat = 1;
        end else if (op == 2'd2) begin
            q  = sa / sb;
            r  = sa % sb;
            qv = q;
            rv = r;
            lo = qv[31:0];
            hi = rv[31:0];
        end else if (op == 2'd3) begin
            lo = a / b;
            hi = a % b;
        end else begin
            if (op == 2'd0) p = sa * sb;
            else            p = {32'd0, a} * {32'd0, b};
            hi = p[63:32];
            lo = p[31:0];
`ifdef MULDIV_EARLY_TERM_EN
            mag = (op == 2'd0 && b[31]) ? -b : b;
            h = -1;
            for (int i = 0; i < 32; i++) if (mag[i]) h = i;
            lat = ((h + 1) < 1 ? 1 : (h + 1)) + 1;
`else
            mag = b;
            h = 0;
`endif
        end
    endtask

    // One complete operation started from IDLE, with an optional MTHI/MTLO write on the start edge.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic wh, input logic wl, input logic [31:0] wd);
        logic [31:0] ehi, elo, phi, plo;
        logic edbz;
        int lat, n, busy_cnt;
        bit done;
        model(op, a, b, ehi, elo, edbz, lat);
        phi = wh ? wd : o_hi;
        plo = wl ? wd : o_lo;
        i_start = 1'b1; i_op = op; i_opA = a; i_opB = b;
        i_wr_hi = wh; i_wr_lo = wl; i_wdata = wd;
        step();
        i_start = 1'b0; i_wr_hi = 1'b0; i_wr_lo = 1'b0;
        i_opA = $urandom; i_opB = $urandom; i_op = 2'($urandom_range(0, 3));
        chk("busy_at_start", 64'(o_busy), 64'd1);
        busy_cnt = 1;
        n = 0;
        done = 0;
        while (!done && n < 100) begin
            step();
            n++;
            if (o_done) done = 1;
            else begin
                if (o_busy) busy_cnt++;
                if (n == 1) begin
                    chk("hold_hi", 64'(o_hi), 64'(phi));
                    chk("hold_lo", 64'(o_lo), 64'(plo));
                end
            end
        end
        chk("latency", 64'(n), 64'(lat));
        chk("busy_cycles", 64'(busy_cnt), 64'(lat));
        chk("busy_at_done", 64'(o_busy), 64'd0);
        chk("hi", 64'(o_hi), 64'(ehi));
        chk("lo", 64'(o_lo), 64'(elo));
        chk("dbz", 64'(o_dbz), 64'(edbz));
    endtask

    initial begin
        logic [31:0] ehi, elo, ra, rb;
        logic edbz;
        int lat, n, poke, done_seen;
        bit done;

        // Reset values.
        #12;
        chk("rst_hi", 64'(o_hi), 64'd0);
        chk("rst_lo", 64'(o_lo), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_dbz", 64'(o_dbz), 64'd0);
        i_rst_n = 1'b1;
        step();

        // Directed cases. Back-to-back starts also issue a start on the edge where o_done is high.
        do_op(2'd0, 32'hFFFF_FFFD, 32'd7, 0, 0, 0);
        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
        do_op(2'd1, 32'd5, 32'd3, 0, 0, 0);
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
        do_op(2'd3, 32'd100, 32'd0, 0, 0, 0);
        do_op(2'd3, 32'd100, 32'd7, 0, 0, 0);
        do_op(2'd2, 32'h1234_5678, 32'd0, 0, 0, 0);
        do_op(2'd0, 32'h8000_0000, 32'h8000_0000, 0, 0, 0);
        do_op(2'd1, 32'hDEAD_BEEF, 32'd0, 0, 0, 0);
        do_op(2'd2, 32'd7, 32'hFFFF_FFFE, 0, 0, 0);
        // A write and a start on the same edge.
        do_op(2'd1, 32'd9, 32'd9, 1, 1, 32'hA5A5_0001);

        // MTLO/MTHI while idle.
        i_wr_lo = 1'b1; i_wdata = 32'h0BAD_F00D;
        step();
        i_wr_lo = 1'b0;
        chk("mtlo", 64'(o_lo), 64'h0BAD_F00D);

        // A start and an MTLO while busy must both be ignored.
        model(2'd1, 32'd2, 32'd3, ehi, elo, edbz, lat);
`ifdef MULDIV_EARLY_TERM_EN
        poke = 1;
`else
        poke = 10;
`endif
        i_start = 1'b1; i_op = 2'd1; i_opA = 32'd2; i_opB = 32'd3;
        step();
        i_start = 1'b0;
        n = 0;
        done = 0;
        while (!done && n < 100) begin
            if (n == poke) begin
                i_start = 1'b1; i_op = 2'd3; i_opA = 32'd50; i_opB = 32'd0;
                i_wr_lo = 1'b1; i_wdata = 32'h55;
            end
            step();
            i_start = 1'b0; i_wr_lo = 1'b0;
            n++;
            if (o_done) done = 1;
        end
        chk("ign_latency", 64'(n), 64'(lat));
        chk("ign_hi", 64'(o_hi), 64'(ehi));
        chk("ign_lo", 64'(o_lo), 64'(elo));
        step();
        chk("ign_busy_after", 64'(o_busy), 64'd0);

        // Reset in flight.
        i_wr_hi = 1'b1; i_wdata = 32'h1234;
        step();
        i_wr_hi = 1'b0;
        chk("mthi", 64'(o_hi), 64'h1234);
        i_start = 1'b1; i_op = 2'd0; i_opA = 32'd7; i_opB = 32'h8000_0001;
        step();
        i_start = 1'b0;
        repeat (14) step();
        i_rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(o_busy), 64'd0);
        chk("abort_hi", 64'(o_hi), 64'd0);
        chk("abort_lo", 64'(o_lo), 64'd0);
        step();
        step();
        i_rst_n = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (o_done || o_busy) done_seen++;
        end
        chk("abort_no_done", 64'(done_seen), 64'd0);
        do_op(2'd0, 32'd2, 32'd2, 0, 0, 0);

        // Random operations.
        for (int t = 0; t < 40; t++) begin
            ra = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
                3:       rb = -($urandom_range(1, 300));
                default: rb = $urandom;
            endcase
            do_op(2'($urandom_range(0, 3)), ra, rb, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
